// File: rtl/score_keeper.sv
// score_keeper: turns Tetris line-clear events into a saturating 0..99 score.
// The score is then converted into two BCD digits by repeated subtraction.
// The digits only change when a conversion completes, so the overlay never
// shows a half-converted value.
//
// Ports:
//   clk          system clock (shared with the VGA pixel-address logic)
//   resetn       asynchronous active-low reset
//   game_start   synchronous clear of score/digits, overrides everything
//   clear_valid  line-clear event request (held by requester until accepted)
//   clear_lines  lines cleared by the event, 1..4 meaningful
//   clear_ready  high only when idle; an event is accepted on valid && ready
//   score        binary score, zero-extended to 32 bits
//   digit1       tens digit (BCD)
//   digit0       ones digit (BCD)
//   score_update one-cycle pulse when digit1/digit0 take a new value
module score_keeper #(
  parameter int unsigned SCORE_MAX = 99
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        game_start,
  input  logic        clear_valid,
  input  logic [2:0]  clear_lines,
  output logic        clear_ready,
  output logic [31:0] score,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        score_update
);

  localparam logic [7:0] ScoreMax = 8'(SCORE_MAX);

  typedef enum logic [1:0] {StIdle, StAdd, StConv} state_e;

  state_e     state_q, state_d;
  logic [3:0] points_q;
  logic [7:0] score_q;
  logic [7:0] rem_q;
  logic [3:0] tens_q;
  logic [3:0] digit1_q, digit0_q;
  logic       update_q;

  logic       accept;
  logic [3:0] points;
  logic [7:0] sum;
  logic [7:0] sum_sat;

  // Point table; illegal counts score nothing but still run a conversion.
  always_comb begin
    unique case (clear_lines)
      3'd1:    points = 4'd1;
      3'd2:    points = 4'd3;
      3'd3:    points = 4'd5;
      3'd4:    points = 4'd8;
      default: points = 4'd0;
    endcase
  end

  assign accept  = clear_valid && clear_ready;
  // score_q <= 99 and points <= 8, so the 8-bit sum cannot wrap.
  assign sum     = score_q + {4'd0, points_q};
  assign sum_sat = (sum > ScoreMax) ? ScoreMax : sum;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (game_start) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (clear_valid) state_d = StAdd;
        StAdd:   state_d = StConv;
        StConv:  if (rem_q < 8'd10) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    clear_ready = (state_q == StIdle);
  end

  // Datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      points_q <= '0;
      score_q  <= '0;
      rem_q    <= '0;
      tens_q   <= '0;
      digit1_q <= '0;
      digit0_q <= '0;
      update_q <= 1'b0;
    end else begin
      update_q <= 1'b0;
      if (game_start) begin
        score_q  <= '0;
        rem_q    <= '0;
        tens_q   <= '0;
        digit1_q <= '0;
        digit0_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) points_q <= points;
          end
          StAdd: begin
            score_q <= sum_sat;
            rem_q   <= sum_sat;
            tens_q  <= '0;
          end
          StConv: begin
            if (rem_q >= 8'd10) begin
              rem_q  <= rem_q - 8'd10;
              tens_q <= tens_q + 4'd1;
            end else begin
              digit1_q <= tens_q;
              digit0_q <= rem_q[3:0];
              update_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign score        = {24'd0, score_q};
  assign digit1       = digit1_q;
  assign digit0       = digit0_q;
  assign score_update = update_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed event sequences, a cycle-level reference
// model built from the point table and latency rules, and literal checks.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        game_start = 1'b0;
  logic        clear_valid = 1'b0;
  logic [2:0]  clear_lines = 3'd0;
  logic        clear_ready;
  logic [31:0] score;
  logic [3:0]  digit1;
  logic [3:0]  digit0;
  logic        score_update;

  score_keeper #(.SCORE_MAX(99)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .game_start   (game_start),
    .clear_valid  (clear_valid),
    .clear_lines  (clear_lines),
    .clear_ready  (clear_ready),
    .score        (score),
    .digit1       (digit1),
    .digit0       (digit0),
    .score_update (score_update)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  int accept_cyc = 0;
  int p0 = 0;

  // Reference model: expected outputs after each edge.
  int m_score = 0;
  int m_d1 = 0;
  int m_d0 = 0;
  int m_busy = 0;  // edges remaining until the digit pulse; 0 means idle
  int m_pend = 0;
  int m_upd = 0;
  int m_addp = 0;

  function automatic int pts(input int lines);
    case (lines)
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_score = 0; m_d1 = 0; m_d0 = 0; m_busy = 0; m_pend = 0; m_upd = 0; m_addp = 0;
    end else begin
      m_upd = 0;
      if (game_start) begin
        m_score = 0; m_d1 = 0; m_d0 = 0; m_busy = 0; m_addp = 0;
      end else if (m_busy == 0) begin
        if (clear_valid) begin
          m_pend = m_score + pts(int'(clear_lines));
          if (m_pend > 99) m_pend = 99;
          m_busy = 2 + m_pend / 10;
          m_addp = 1;
        end
      end else begin
        if (m_addp != 0) begin
          m_score = m_pend;
          m_addp = 0;
        end
        m_busy--;
        if (m_busy == 0) begin
          m_d1 = m_pend / 10;
          m_d0 = m_pend % 10;
          m_upd = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("score", int'(score), m_score);
    check("digit1", int'(digit1), m_d1);
    check("digit0", int'(digit0), m_d0);
    check("score_update", int'(score_update), m_upd);
    check("clear_ready", int'(clear_ready), (m_busy == 0) ? 1 : 0);
    if (score_update) begin
      pulses++;
      last_pulse_cyc = cyc;
    end
  end

  // Entered and left just after a negedge; returns after the accept edge.
  task automatic send(input int lines);
    int n = 0;
    clear_valid = 1'b1;
    clear_lines = 3'(lines);
    while (!clear_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_timeout", int'(clear_ready), 1);
    @(negedge clk);
    accept_cyc = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    clear_valid = 1'b0;
    while (!clear_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("done_timeout", int'(clear_ready), 1);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic clear_game();
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  // Reaches 8*fours + ones, issuing events back-to-back.
  task automatic build(input int fours, input int ones);
    repeat (fours) send(4);
    repeat (ones) send(1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    resetn = 1'b1;
    idle(4);
    check("rst_score", int'(score), 0);
    check("rst_digits", int'({digit1, digit0}), 0);
    check("rst_ready", int'(clear_ready), 1);
    check("rst_pulses", pulses, 0);

    // Single 4-line event from 0.
    send(4);
    wait_done();
    check("single_score", int'(score), 8);
    check("single_d1", int'(digit1), 0);
    check("single_d0", int'(digit0), 8);
    check("single_latency", last_pulse_cyc - accept_cyc, 2);

    // Back-to-back 1,2,3,4 with valid held.
    clear_game();
    p0 = pulses;
    send(1); send(2); send(3); send(4);
    wait_done();
    check("acc_score", int'(score), 17);
    check("acc_d1", int'(digit1), 1);
    check("acc_d0", int'(digit0), 7);
    check("acc_pulses", pulses - p0, 4);
    check("acc_latency", last_pulse_cyc - accept_cyc, 3);

    // Saturation from 95.
    clear_game();
    repeat (11) send(4);
    send(3);
    build(0, 2);
    check("pre_sat_score", int'(score), 95);
    send(4);
    wait_done();
    check("sat_score", int'(score), 99);
    check("sat_d1", int'(digit1), 9);
    check("sat_d0", int'(digit0), 9);
    check("sat_latency", last_pulse_cyc - accept_cyc, 11);
    p0 = pulses;
    send(2);
    wait_done();
    check("sat2_score", int'(score), 99);
    check("sat2_pulses", pulses - p0, 1);
    check("sat2_latency", last_pulse_cyc - accept_cyc, 11);

    // Illegal line counts from 42.
    clear_game();
    build(5, 2);
    p0 = pulses;
    send(0);
    send(6);
    wait_done();
    check("ill_score", int'(score), 42);
    check("ill_d1", int'(digit1), 4);
    check("ill_d0", int'(digit0), 2);
    check("ill_pulses", pulses - p0, 2);

    // game_start during conversion.
    clear_game();
    build(11, 2);
    check("pre_cancel_d1", int'(digit1), 9);
    p0 = pulses;
    send(4);
    clear_valid = 1'b0;
    idle(3);
    clear_game();
    idle(15);
    check("gs_score", int'(score), 0);
    check("gs_digits", int'({digit1, digit0}), 0);
    check("gs_ready", int'(clear_ready), 1);
    check("gs_pulses", pulses - p0, 0);

    // Asynchronous reset during conversion.
    build(11, 2);
    p0 = pulses;
    send(4);
    clear_valid = 1'b0;
    idle(4);
    #2 resetn = 1'b0;
    #1;
    check("ar_score", int'(score), 0);
    check("ar_d1", int'(digit1), 0);
    check("ar_d0", int'(digit0), 0);
    check("ar_ready", int'(clear_ready), 1);
    @(negedge clk);
    resetn = 1'b1;
    idle(15);
    check("ar_pulses", pulses - p0, 0);
    check("ar_score_after", int'(score), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-side producer of the score shown by the VGA score overlay. The block accepts line-clear events from the Tetris game logic and converts lines cleared into points. It accumulates a saturating score and converts it sequentially into two decimal digits. It drives the 32-bit `score` bus and the tens/ones digits consumed by the display path, and holds the digits stable between updates so the overlay never shows a partially converted value.

## Interface

- `SCORE_MAX`, 99, saturation ceiling of the score. Legal range is 0..99, because the display has two digits.
- `clk` input 1: system clock, the same clock as the VGA pixel-address logic.
- `resetn` input 1: asynchronous, active-low reset.
- `game_start` input 1: synchronous score clear, active high, level-sampled each cycle.
- `clear_valid` input 1: line-clear event request.
- `clear_lines` input 3: number of lines cleared by the event. Only 1..4 are meaningful.
- `clear_ready` output 1: the block can accept an event. High only in IDLE.
- `score` output 32: binary score, zero-extended.
- `digit1` output 4: tens digit, BCD.
- `digit0` output 4: ones digit, BCD.
- `score_update` output 1: one-cycle pulse when `digit1`/`digit0` take a new value.

## Operation

- Point table for `clear_lines`:
  - 1 → 1 point
  - 2 → 3 points
  - 3 → 5 points
  - 4 → 8 points
  - 0 or 5..7 → 0 points. The event is still accepted and still runs a conversion.
- Handshake: an event is accepted on a rising edge where `clear_valid && clear_ready`. `clear_lines` is sampled on that edge only. While `clear_ready` is low, `clear_valid` is ignored; the requester must hold it.
- States and transitions:
  - IDLE: `clear_ready`=1. On accept, register the point value and go to ADD.
  - ADD: `score` ← min(`score` + points, `SCORE_MAX`), using 8-bit internal arithmetic. Working remainder `rem` ← new score, `tens` ← 0. Go to CONV.
  - CONV, when `rem` ≥ 10: `rem` ← `rem` − 10, `tens` ← `tens` + 1, stay in CONV.
  - CONV, when `rem` < 10: `digit1` ← `tens`, `digit0` ← `rem`[3:0], `score_update` ← 1 for one cycle, go to IDLE.
- `digit1`/`digit0` change only on the CONV exit edge. They are never written with intermediate values.
- `game_start` high on any edge, in any state:
  - `score`, `digit1`, `digit0`, `rem` and `tens` go to 0, and the state goes to IDLE.
  - No `score_update` pulse is produced.
  - It overrides a simultaneous accept; that event is dropped.
- Reset values while `resetn` is low:
  - state IDLE.
  - `score`=0, `digit1`=0, `digit0`=0, `score_update`=0.
  - `clear_ready`=1, since it is decoded from the state.
- Reset asserted mid-conversion discards the event.

## Timing

- Accept at edge N → `score` is updated at edge N+1 (ADD).
- Conversion of score S takes floor(S/10)+1 CONV cycles. Digits and the `score_update` pulse appear at edge N+2+floor(S/10).
- Worst case with S=99 is 11 cycles from accept to digits.
- `clear_ready` falls at edge N and rises on the same edge that pulses `score_update`. The next event can therefore be accepted on the following edge.
- Back-to-back throughput is one event per 3+floor(S/10) cycles.
- `score_update` is high for exactly one cycle per accepted event, except when the event is cancelled by `game_start` or reset.
- All outputs are registered except `clear_ready`, which is decoded combinationally from the state.

## Test plan

- Reset then idle: `resetn` low then high with no events → `score`=0, digits 0/0, `clear_ready`=1, no `score_update` pulse.
- Single event, `clear_lines`=4 from score 0 → `score`=8 at N+1; `digit1`=0, `digit0`=8 with `score_update` pulse at N+2; `clear_ready` low for cycles N..N+1.
- Accumulate 1, 2, 3, 4 lines back-to-back with `clear_valid` held high (1+3+5+8) → final `score`=17, digits 1/7. Exactly four `score_update` pulses. The last conversion takes 2 CONV cycles.
- Saturation: from score 95, clear 4 lines → `score`=99, digits 9/9, pulse at N+11. A further 2-line clear keeps `score`=99 and still pulses.
- Illegal counts: `clear_lines`=0 and then 6 from score 42 → each event is accepted, `score` stays 42, digits stay 4/2, one pulse per event.
- Cancellation: accept a 4-line event at score 90, then assert `game_start` during CONV → `score`=0, digits 0/0, IDLE, no pulse. Repeat with `resetn` low mid-CONV → same result asynchronously.
